// File: rtl/uart_baud_pkg.sv
// Shared constants, divisor helper and FSM state encoding for the UART baud engine.
package uart_baud_pkg;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  localparam longint unsigned BAUD_RATES [0:7] = '{
    64'd9600, 64'd19200, 64'd38400, 64'd57600,
    64'd115200, 64'd230400, 64'd460800, 64'd921600
  };

  // Oversample divisor minus one; with frac set the result is in 1/16 clock units.
  function automatic longint unsigned baud_div(
    input longint unsigned sys_hz,
    input longint unsigned baud,
    input longint unsigned os,
    input bit              frac
  );
    longint unsigned den;
    longint unsigned q;
    den = baud * os;
    if (frac) begin
      q = (64'd16 * sys_hz + den / 64'd2) / den;
      q = (q < 64'd32) ? 64'd16 : q - 64'd16;
    end else begin
      q = sys_hz / den;
      q = (q < 64'd2) ? 64'd1 : q - 64'd1;
    end
    return q;
  endfunction

endpackage

// File: rtl/uart_os_divider.sv
// Oversample period counter; o_hit marks the last cycle of each period.
// With UART_BAUD_FRAC_EN the low 4 divisor bits drive a fraction accumulator.
module uart_os_divider #(
  parameter int CNT_W = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_hit
);

`ifdef UART_BAUD_FRAC_EN
  localparam int INT_W = CNT_W - 4;

  logic [INT_W-1:0] r_cnt;
  logic [3:0]       r_acc;
  logic [4:0]       w_sum;
  logic [INT_W-1:0] w_limit;
  logic             w_hit;

  // The period whose fraction overflows is the one stretched, so any 16 periods
  // add up to exactly 16*(D+1) + fraction cycles.
  assign w_sum   = {1'b0, r_acc} + {1'b0, i_div[3:0]};
  assign w_limit = i_div[CNT_W-1:4] + INT_W'(w_sum[4]);
  assign w_hit   = i_en && (r_cnt == w_limit);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_en) begin
      if (w_hit) begin
        r_cnt <= '0;
        r_acc <= w_sum[3:0];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit = i_en && (r_cnt == i_div);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
    end
  end
`endif

  assign o_hit = w_hit;

endmodule

// File: rtl/uart_baud_engine.sv
// UART baud/tick engine: latches a divisor on Start, then emits oversample, mid-bit and bit
// ticks for one frame before pulsing Done. Define UART_BAUD_FRAC_EN for a fractional divisor.
//
// state | meaning
// IDLE  | waiting for Start; all ticks low
// RUN   | frame in progress; the Done cycle is the last RUN cycle
module uart_baud_engine
  import uart_baud_pkg::*;
#(
  parameter int SYS_CLK_HZ = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 16,
  parameter int FRAME_BITS = 10
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic [2:0]       i_Baud_Set,
  input  logic             i_Div_Load,
  input  logic [CNT_W-1:0] i_Div_Value,
  input  logic             i_Use_Custom,
  input  logic             i_Start,
  input  logic             i_Stop,
  output logic             o_Busy,
  output logic             o_Bit_Tick,
  output logic             o_Mid_Tick,
  output logic             o_Os_Tick,
  output logic             o_Done
);

`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC = 1'b1;
`else
  localparam bit FRAC = 1'b0;
`endif

  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam longint unsigned SYS_HZ_L = 64'(SYS_CLK_HZ);
  localparam longint unsigned OS_L     = 64'(OVERSAMPLE);

  localparam logic [CNT_W-1:0] DIV_TABLE [0:7] = '{
    CNT_W'(baud_div(SYS_HZ_L, BAUD_RATES[0], OS_L, FRAC)),
    CNT_W'(baud_div(SYS_HZ_L, BAUD_RATES[1], OS_L, FRAC)),
    CNT_W'(baud_div(SYS_HZ_L, BAUD_RATES[2], OS_L, FRAC)),
    CNT_W'(baud_div(SYS_HZ_L, BAUD_RATES[3], OS_L, FRAC)),
    CNT_W'(baud_div(SYS_HZ_L, BAUD_RATES[4], OS_L, FRAC)),
    CNT_W'(baud_div(SYS_HZ_L, BAUD_RATES[5], OS_L, FRAC)),
    CNT_W'(baud_div(SYS_HZ_L, BAUD_RATES[6], OS_L, FRAC)),
    CNT_W'(baud_div(SYS_HZ_L, BAUD_RATES[7], OS_L, FRAC))
  };

  state_t           r_state;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_custom;
  logic [IDX_W-1:0] r_os_idx;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_bit_tick;
  logic             r_mid_tick;
  logic             r_os_tick;
  logic             r_done;

  logic w_hit;
  logic w_start_acc;
  logic w_running;

  assign w_start_acc = (r_state == IDLE) && i_Start && !i_Stop;
  assign w_running   = (r_state == RUN) && !r_done;

  uart_os_divider #(
    .CNT_W (CNT_W)
  ) u_os_divider (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_en    (w_running),
    .i_load  (w_start_acc),
    .i_div   (r_div),
    .o_hit   (w_hit)
  );

  // Ticks are registered one cycle after the divider hit, which makes every bit
  // period exactly (D+1)*OVERSAMPLE cycles measured from the start tick.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_custom   <= '0;
      r_os_idx   <= '0;
      r_bit_cnt  <= '0;
      r_bit_tick <= 1'b0;
      r_mid_tick <= 1'b0;
      r_os_tick  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_bit_tick <= 1'b0;
      r_mid_tick <= 1'b0;
      r_os_tick  <= 1'b0;
      r_done     <= 1'b0;
      if (i_Div_Load) r_custom <= i_Div_Value;
      case (r_state)
        IDLE: begin
          if (w_start_acc) begin
            r_state    <= RUN;
            r_div      <= i_Use_Custom ? r_custom : DIV_TABLE[i_Baud_Set];
            r_os_idx   <= '0;
            r_bit_cnt  <= '0;
            r_bit_tick <= 1'b1;
          end
        end
        RUN: begin
          if (i_Stop || r_done) begin
            r_state <= IDLE;
          end else if (w_hit) begin
            r_os_tick  <= 1'b1;
            r_mid_tick <= (r_os_idx == IDX_MID);
            if (r_os_idx == IDX_LAST) begin
              r_os_idx <= '0;
              if (r_bit_cnt == BIT_LAST) begin
                r_done <= 1'b1;
              end else begin
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                r_bit_tick <= 1'b1;
              end
            end else begin
              r_os_idx <= r_os_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_Busy     = (r_state == RUN);
  assign o_Bit_Tick = r_bit_tick;
  assign o_Mid_Tick = r_mid_tick;
  assign o_Os_Tick  = r_os_tick;
  assign o_Done     = r_done;

endmodule

// File: tb/tb_uart_baud_engine.sv
// Bench for uart_baud_engine: frames checked cycle by cycle against tick times computed
// arithmetically from the divisor. Build with UART_BAUD_FRAC_EN defined for the fractional case.
`timescale 1ns/1ps
module tb_uart_baud_engine;
  localparam int SYS_HZ = 50_000_000;
  localparam int OS     = 16;
  localparam int FB     = 10;
`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC = 1'b1;
`else
  localparam bit FRAC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  baud_set = 3'd0;
  logic        div_load = 1'b0;
  logic [15:0] div_value = 16'd0;
  logic        use_custom = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        o_Busy, o_Bit_Tick, o_Mid_Tick, o_Os_Tick, o_Done;

  int checks = 0;
  int errors = 0;
  int m_custom = 0;
  int BAUDS [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

  uart_baud_engine dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Baud_Set   (baud_set),
    .i_Div_Load   (div_load),
    .i_Div_Value  (div_value),
    .i_Use_Custom (use_custom),
    .i_Start      (start),
    .i_Stop       (stop),
    .o_Busy       (o_Busy),
    .o_Bit_Tick   (o_Bit_Tick),
    .o_Mid_Tick   (o_Mid_Tick),
    .o_Os_Tick    (o_Os_Tick),
    .o_Done       (o_Done)
  );

  always #5 clk = ~clk;

  function automatic int tbl(input int idx);
    longint q, den;
    den = longint'(BAUDS[idx]) * OS;
    if (FRAC) begin
      q = (16 * longint'(SYS_HZ) + den / 2) / den - 16;
      if (q < 16) q = 16;
    end else begin
      q = longint'(SYS_HZ) / den - 1;
      if (q < 1) q = 1;
    end
    return int'(q);
  endfunction

  // Offset (from the start tick) at which oversample tick j appears.
  function automatic int ostime(input int j, input int ip, input int fp);
    return j * (ip + 1) + (j * fp) / 16;
  endfunction

  task automatic load_custom(input int v);
    @(negedge clk);
    div_load = 1'b1;
    div_value = 16'(v);
    @(negedge clk);
    div_load = 1'b0;
    m_custom = v;
  endtask

  task automatic run_frame(input int v, input int abort_at, input bit disturb,
                           input bit done_start, input string name);
    int ip, fp, t_done, t_end, j, t_next, bad, first_bad, newv;
    bit os_e;
    logic [4:0] got, exp, fg, fe;
    ip = FRAC ? (v >> 4) : v;
    fp = FRAC ? (v & 15) : 0;
    t_done = ostime(OS * FB, ip, fp);
    t_end = (abort_at >= 0) ? abort_at + 8 : t_done + 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 1;
    t_next = ostime(1, ip, fp);
    bad = 0;
    first_bad = -1;
    fg = '0;
    fe = '0;
    for (int t = 0; t <= t_end; t++) begin
      if (t > 0) @(negedge clk);
      os_e = (t == t_next) && (j <= OS * FB);
      exp[4] = (t <= t_done);
      exp[3] = (t == 0) || (os_e && (j % OS == 0) && (j < OS * FB));
      exp[2] = os_e && (j % OS == OS / 2);
      exp[1] = os_e;
      exp[0] = os_e && (j == OS * FB);
      if (abort_at >= 0 && t > abort_at) exp = '0;
      got = {o_Busy, o_Bit_Tick, o_Mid_Tick, o_Os_Tick, o_Done};
      if (got !== exp) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = t;
          fg = got;
          fe = exp;
        end
      end
      if (os_e) begin
        j++;
        t_next = ostime(j, ip, fp);
      end
      stop = (t == abort_at);
      start = (disturb && t == 5) || (done_start && abort_at < 0 && t == t_done);
      div_load = disturb && t == 5;
      if (disturb && (t == 5 || t == 6)) begin
        use_custom = ~use_custom;
        baud_set = baud_set ^ 3'b101;
      end
      if (disturb && t == 5) begin
        newv = FRAC ? int'($urandom_range(0, 159)) : int'($urandom_range(0, 9));
        div_value = 16'(newv);
        m_custom = newv;
      end
    end
    stop = 1'b0;
    start = 1'b0;
    div_load = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s: first bad offset %0d busy/bit/mid/os/done got %b expected %b (%0d bad cycles)",
               name, first_bad, fg, fe, bad);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {o_Busy, o_Bit_Tick, o_Mid_Tick, o_Os_Tick, o_Done};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected 00000", got);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_baud115200();
    baud_set = 3'd4;
    use_custom = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    run_frame(tbl(4), -1, 1'b0, 1'b0, "baud_115200");
`else
    run_frame(26, -1, 1'b0, 1'b1, "baud_115200");
`endif
  endtask

  task automatic test_custom();
    load_custom(FRAC ? 48 : 3);
    use_custom = 1'b1;
    run_frame(FRAC ? 48 : 3, -1, 1'b1, 1'b0, "custom_div3_disturbed");
  endtask

  task automatic test_stop();
    use_custom = 1'b0;
    baud_set = 3'd0;
`ifdef UART_BAUD_FRAC_EN
    run_frame(tbl(0), 1000, 1'b0, 1'b0, "stop_9600");
`else
    run_frame(324, 1000, 1'b0, 1'b0, "stop_9600");
`endif
    use_custom = 1'b1;
    run_frame(m_custom, -1, 1'b0, 1'b0, "restart_after_stop");
  endtask

  task automatic test_start_stop_idle();
    int bad;
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    bad = 0;
    repeat (5) begin
      if ({o_Busy, o_Bit_Tick, o_Mid_Tick, o_Os_Tick, o_Done} !== 5'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL start_stop_idle: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_random();
    int v, ab;
    for (int i = 0; i < 8; i++) begin
      v = FRAC ? int'($urandom_range(0, 159)) : int'($urandom_range(0, 9));
      load_custom(v);
      use_custom = 1'b1;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 150)) : -1;
      run_frame(v, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_table();
    use_custom = 1'b0;
    for (int b = 5; b < 8; b++) begin
      baud_set = 3'(b);
      run_frame(tbl(b), -1, 1'b0, 1'b0, $sformatf("table_%0d", b));
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    int bad;
    load_custom(FRAC ? 80 : 5);
    use_custom = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    got = {o_Busy, o_Bit_Tick, o_Mid_Tick, o_Os_Tick, o_Done};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_clear: got %b expected 00000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_custom = 0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if ({o_Busy, o_Bit_Tick, o_Mid_Tick, o_Os_Tick, o_Done} !== 5'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet: %0d active cycles, expected 0", bad);
    end
    run_frame(m_custom, -1, 1'b0, 1'b0, "custom_cleared_by_reset");
  endtask

`ifdef UART_BAUD_FRAC_EN
  task automatic test_frac();
    use_custom = 1'b0;
    baud_set = 3'd7;
    run_frame(38, -1, 1'b0, 1'b0, "frac_921600");
  endtask
`endif

  initial begin
    test_reset();
    test_baud115200();
    test_custom();
    test_stop();
    test_start_stop_idle();
    test_random();
    test_table();
    test_reset_mid();
`ifdef UART_BAUD_FRAC_EN
    test_frac();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
